// File: rtl/recepcao_serial_n.sv
// Serial (UART-style) receiver that assembles BYTES_PALAVRA bytes into one word.
// Frames are start + DATA_BITS data (LSB first) + optional parity + stop.
// Errors discard the partial word. palavra changes only when a word completes.
module recepcao_serial_n #(
    parameter int CLK_P_BIT     = 5208,
    parameter int DATA_BITS     = 8,
    parameter int PARIDADE      = 1,
    parameter int BYTES_PALAVRA = 2,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               habilita,
    input  logic                               rx_serial,
    output logic [DATA_BITS*BYTES_PALAVRA-1:0] palavra,
    output logic                               pronto,
    output logic                               erro_paridade,
    output logic                               erro_quadro,
    output logic                               erro_timeout,
    output logic [3:0]                         db_estado
);

    localparam int WORD_W  = DATA_BITS * BYTES_PALAVRA;
    localparam int GAP_CYC = TIMEOUT_BITS * CLK_P_BIT;
    localparam int MEIO    = (CLK_P_BIT / 2 > 0) ? CLK_P_BIT / 2 : 1;
    localparam int CW      = (CLK_P_BIT > 1) ? $clog2(CLK_P_BIT) : 1;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int IW      = (BYTES_PALAVRA > 1) ? $clog2(BYTES_PALAVRA) : 1;

    localparam logic [CW-1:0] BIT_FIM  = CW'(CLK_P_BIT - 1);
    localparam logic [CW-1:0] MEIO_FIM = CW'(MEIO - 1);
    localparam logic [GW-1:0] GAP_FIM  = GW'(GAP_CYC - 1);
    localparam logic [BW-1:0] ULT_BIT  = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] ULT_IDX  = IW'(BYTES_PALAVRA - 1);

    typedef enum logic [2:0] {
        EST_OCIOSO       = 3'd0,
        EST_START        = 3'd1,
        EST_DADOS        = 3'd2,
        EST_PARIDADE     = 3'd3,
        EST_STOP         = 3'd4,
        EST_ARMAZENA     = 3'd5,
        EST_ESPERA       = 3'd6,
        EST_AGUARDA_ALTO = 3'd7
    } estado_t;

    estado_t               estado;
    logic                  rx_meta;
    logic                  rx_sinc;
    logic                  rx_ant;
    logic [CW-1:0]         cnt_bit;
    logic [GW-1:0]         cnt_gap;
    logic [BW-1:0]         n_bit;
    logic [IW-1:0]         idx;
    logic [DATA_BITS-1:0]  dado;
    logic                  bit_par;
    logic [WORD_W-1:0]     buffer;
    logic [WORD_W-1:0]     buffer_novo;
    logic                  borda;
    logic                  xor_total;
    logic                  paridade_ok;

    assign db_estado = {1'b0, estado};
    assign borda     = rx_ant & ~rx_sinc;
    assign xor_total = (^dado) ^ bit_par;
    assign paridade_ok = (PARIDADE == 1) ? xor_total : ~xor_total;

    // Buffer with the current byte merged into its lane, used by ARMAZENA
    always_comb begin
        buffer_novo = buffer;
        buffer_novo[idx*DATA_BITS +: DATA_BITS] = dado;
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sinc <= 1'b1;
            rx_ant  <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sinc <= rx_meta;
            rx_ant  <= rx_sinc;
        end
    end

    // Reception FSM: bit timing, byte assembly, word output and error pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= EST_OCIOSO;
            cnt_bit       <= '0;
            cnt_gap       <= '0;
            n_bit         <= '0;
            idx           <= '0;
            dado          <= '0;
            bit_par       <= 1'b0;
            buffer        <= '0;
            palavra       <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_timeout  <= 1'b0;
        end else begin
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_timeout  <= 1'b0;
            case (estado)
                EST_OCIOSO: begin
                    if (habilita && borda) begin
                        estado  <= EST_START;
                        cnt_bit <= '0;
                        n_bit   <= '0;
                    end
                end
                EST_START: begin
                    if (cnt_bit == MEIO_FIM) begin
                        cnt_bit <= '0;
                        n_bit   <= '0;
                        if (rx_sinc) begin
                            estado <= EST_OCIOSO;
                        end else begin
                            estado <= EST_DADOS;
                        end
                    end else begin
                        cnt_bit <= cnt_bit + 1'b1;
                    end
                end
                EST_DADOS: begin
                    if (cnt_bit == BIT_FIM) begin
                        cnt_bit <= '0;
                        dado    <= {rx_sinc, dado[DATA_BITS-1:1]};
                        if (n_bit == ULT_BIT) begin
                            if (PARIDADE != 0) begin
                                estado <= EST_PARIDADE;
                            end else begin
                                estado <= EST_STOP;
                            end
                        end else begin
                            n_bit <= n_bit + 1'b1;
                        end
                    end else begin
                        cnt_bit <= cnt_bit + 1'b1;
                    end
                end
                EST_PARIDADE: begin
                    if (cnt_bit == BIT_FIM) begin
                        cnt_bit <= '0;
                        bit_par <= rx_sinc;
                        estado  <= EST_STOP;
                    end else begin
                        cnt_bit <= cnt_bit + 1'b1;
                    end
                end
                EST_STOP: begin
                    if (cnt_bit == BIT_FIM) begin
                        cnt_bit <= '0;
                        // Framing error outranks parity error
                        if (!rx_sinc) begin
                            erro_quadro <= 1'b1;
                            buffer      <= '0;
                            idx         <= '0;
                            estado      <= EST_AGUARDA_ALTO;
                        end else if ((PARIDADE != 0) && !paridade_ok) begin
                            erro_paridade <= 1'b1;
                            buffer        <= '0;
                            idx           <= '0;
                            estado        <= EST_AGUARDA_ALTO;
                        end else begin
                            estado <= EST_ARMAZENA;
                        end
                    end else begin
                        cnt_bit <= cnt_bit + 1'b1;
                    end
                end
                EST_ARMAZENA: begin
                    if (idx == ULT_IDX) begin
                        palavra <= buffer_novo;
                        pronto  <= 1'b1;
                        buffer  <= '0;
                        idx     <= '0;
                        estado  <= EST_OCIOSO;
                    end else begin
                        buffer  <= buffer_novo;
                        idx     <= idx + 1'b1;
                        cnt_gap <= '0;
                        estado  <= EST_ESPERA;
                    end
                end
                EST_ESPERA: begin
                    // A start edge wins over a timeout expiring in the same cycle
                    if (borda) begin
                        cnt_bit <= '0;
                        n_bit   <= '0;
                        estado  <= EST_START;
                    end else if (cnt_gap == GAP_FIM) begin
                        erro_timeout <= 1'b1;
                        buffer       <= '0;
                        idx          <= '0;
                        estado       <= EST_OCIOSO;
                    end else begin
                        cnt_gap <= cnt_gap + 1'b1;
                    end
                end
                EST_AGUARDA_ALTO: begin
                    if (!rx_sinc) begin
                        cnt_bit <= '0;
                    end else if (cnt_bit == BIT_FIM) begin
                        cnt_bit <= '0;
                        estado  <= EST_OCIOSO;
                    end else begin
                        cnt_bit <= cnt_bit + 1'b1;
                    end
                end
                default: begin
                    estado <= EST_OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recepcao_serial_n.sv
// Directed bench for recepcao_serial_n: two instances with short bit periods,
// one odd-parity 2-byte config and one even-parity 3-byte config.
module tb_recepcao_serial_n;

    localparam int CPB_A = 16;
    localparam int CPB_B = 8;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, hab_a, hab_b, rx_a, rx_b;
    logic [15:0] palavra_a;
    logic [23:0] palavra_b;
    logic        pronto_a, par_a, quad_a, to_a;
    logic        pronto_b, par_b, quad_b, to_b;
    logic [3:0]  db_a, db_b;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int a_pr = 0, a_par = 0, a_quad = 0, a_to = 0, a_busy = 0;
    int a_last_stop = 0, a_last_arm = 0, a_pr_cyc = 0, a_to_cyc = 0;
    int b_pr = 0, b_err = 0;

    recepcao_serial_n #(
        .CLK_P_BIT(CPB_A), .DATA_BITS(8), .PARIDADE(1), .BYTES_PALAVRA(2), .TIMEOUT_BITS(20)
    ) dut_a (
        .clock(clk), .reset(rst_a), .habilita(hab_a), .rx_serial(rx_a),
        .palavra(palavra_a), .pronto(pronto_a), .erro_paridade(par_a),
        .erro_quadro(quad_a), .erro_timeout(to_a), .db_estado(db_a)
    );

    recepcao_serial_n #(
        .CLK_P_BIT(CPB_B), .DATA_BITS(8), .PARIDADE(2), .BYTES_PALAVRA(3), .TIMEOUT_BITS(20)
    ) dut_b (
        .clock(clk), .reset(rst_b), .habilita(hab_b), .rx_serial(rx_b),
        .palavra(palavra_b), .pronto(pronto_b), .erro_paridade(par_b),
        .erro_quadro(quad_b), .erro_timeout(to_b), .db_estado(db_b)
    );

    always #5 clk = ~clk;

    // Event monitor sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (db_a == 4'd4) a_last_stop = cyc;
        if (db_a == 4'd5) a_last_arm = cyc;
        if (db_a != 4'd0) a_busy = a_busy + 1;
        if (pronto_a) begin a_pr = a_pr + 1; a_pr_cyc = cyc; end
        if (par_a) a_par = a_par + 1;
        if (quad_a) a_quad = a_quad + 1;
        if (to_a) begin a_to = a_to + 1; a_to_cyc = cyc; end
        if (pronto_b) b_pr = b_pr + 1;
        if (par_b | quad_b | to_b) b_err = b_err + 1;
    end

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    // mode 1 = odd, 2 = even; flip inverts the parity bit
    task automatic send_frame(input bit sel, input int cpb, input int mode,
                              input logic [7:0] d, input bit flip, input logic stop_v);
        logic p;
        p = (mode == 1) ? ~(^d) : ^d;
        p = p ^ flip;
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, d[i], cpb);
        drive(sel, p, cpb);
        drive(sel, stop_v, cpb);
        drive(sel, 1'b1, 0);
    endtask

    task automatic test_reset;
        #1;
        checks++; if (palavra_a !== 16'h0000) begin errors++; $display("FAIL reset_palavra_a got %h exp 0000", palavra_a); end
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL reset_estado_a got %0d exp 0", db_a); end
        checks++; if ({pronto_a, par_a, quad_a, to_a} !== 4'b0000) begin errors++; $display("FAIL reset_pulsos_a got %b exp 0000", {pronto_a, par_a, quad_a, to_a}); end
        checks++; if (palavra_b !== 24'h000000) begin errors++; $display("FAIL reset_palavra_b got %h exp 000000", palavra_b); end
        checks++; if (db_b !== 4'd0) begin errors++; $display("FAIL reset_estado_b got %0d exp 0", db_b); end
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_two_bytes;
        int p0, e0;
        p0 = a_pr; e0 = a_par + a_quad + a_to;
        send_frame(0, CPB_A, 1, 8'h02, 0, 1'b1);
        send_frame(0, CPB_A, 1, 8'h22, 0, 1'b1);
        drive(0, 1'b1, 3 * CPB_A); #1;
        checks++; if (a_pr - p0 !== 1) begin errors++; $display("FAIL word1_pronto got %0d exp 1", a_pr - p0); end
        checks++; if (palavra_a !== 16'h2202) begin errors++; $display("FAIL word1_palavra got %h exp 2202", palavra_a); end
        checks++; if (a_par + a_quad + a_to - e0 !== 0) begin errors++; $display("FAIL word1_erros got %0d exp 0", a_par + a_quad + a_to - e0); end
        checks++; if (a_pr_cyc - a_last_stop !== 2) begin errors++; $display("FAIL pronto_latencia got %0d exp 2", a_pr_cyc - a_last_stop); end
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL word1_estado got %0d exp 0", db_a); end
    endtask

    task automatic test_parity_error;
        int p0, pe0, q0;
        p0 = a_pr; pe0 = a_par; q0 = a_quad;
        send_frame(0, CPB_A, 1, 8'h34, 1, 1'b1);
        drive(0, 1'b1, 2 * CPB_A); #1;
        checks++; if (a_par - pe0 !== 1) begin errors++; $display("FAIL par_pulso got %0d exp 1", a_par - pe0); end
        checks++; if (a_quad - q0 !== 0) begin errors++; $display("FAIL par_sem_quadro got %0d exp 0", a_quad - q0); end
        checks++; if (palavra_a !== 16'h2202) begin errors++; $display("FAIL par_palavra_mantida got %h exp 2202", palavra_a); end
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL par_retorno_ocioso got %0d exp 0", db_a); end
        send_frame(0, CPB_A, 1, 8'h34, 0, 1'b1);
        send_frame(0, CPB_A, 1, 8'h12, 0, 1'b1);
        drive(0, 1'b1, 3 * CPB_A); #1;
        checks++; if (a_pr - p0 !== 1) begin errors++; $display("FAIL word2_pronto got %0d exp 1", a_pr - p0); end
        checks++; if (palavra_a !== 16'h1234) begin errors++; $display("FAIL word2_palavra got %h exp 1234", palavra_a); end
        checks++; if (a_par - pe0 !== 1) begin errors++; $display("FAIL word2_par_extra got %0d exp 1", a_par - pe0); end
    endtask

    task automatic test_frame_error;
        int p0, pe0, q0;
        p0 = a_pr; pe0 = a_par; q0 = a_quad;
        send_frame(0, CPB_A, 1, 8'h55, 0, 1'b0);
        drive(0, 1'b1, CPB_A + 4); #1;
        checks++; if (a_quad - q0 !== 1) begin errors++; $display("FAIL quadro_pulso got %0d exp 1", a_quad - q0); end
        checks++; if (a_par - pe0 !== 0) begin errors++; $display("FAIL quadro_sem_par got %0d exp 0", a_par - pe0); end
        checks++; if (palavra_a !== 16'h1234) begin errors++; $display("FAIL quadro_palavra_mantida got %h exp 1234", palavra_a); end
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL quadro_retorno_ocioso got %0d exp 0", db_a); end
        send_frame(0, CPB_A, 1, 8'h01, 0, 1'b1);
        send_frame(0, CPB_A, 1, 8'h10, 0, 1'b1);
        drive(0, 1'b1, 3 * CPB_A); #1;
        checks++; if (a_pr - p0 !== 1) begin errors++; $display("FAIL word3_pronto got %0d exp 1", a_pr - p0); end
        checks++; if (palavra_a !== 16'h1001) begin errors++; $display("FAIL word3_palavra got %h exp 1001", palavra_a); end
        // Stop low together with bad parity: only the framing error is reported
        pe0 = a_par; q0 = a_quad;
        send_frame(0, CPB_A, 1, 8'h55, 1, 1'b0);
        drive(0, 1'b1, CPB_A + 4); #1;
        checks++; if (a_quad - q0 !== 1) begin errors++; $display("FAIL prioridade_quadro got %0d exp 1", a_quad - q0); end
        checks++; if (a_par - pe0 !== 0) begin errors++; $display("FAIL prioridade_sem_par got %0d exp 0", a_par - pe0); end
    endtask

    task automatic test_timeout;
        int p0, t0;
        p0 = a_pr; t0 = a_to;
        send_frame(0, CPB_A, 1, 8'h00, 0, 1'b1);
        drive(0, 1'b1, 25 * CPB_A); #1;
        checks++; if (a_to - t0 !== 1) begin errors++; $display("FAIL timeout_pulso got %0d exp 1", a_to - t0); end
        checks++; if (a_to_cyc - a_last_arm !== 20 * CPB_A + 1) begin errors++; $display("FAIL timeout_instante got %0d exp %0d", a_to_cyc - a_last_arm, 20 * CPB_A + 1); end
        checks++; if (palavra_a !== 16'h1001) begin errors++; $display("FAIL timeout_palavra_mantida got %h exp 1001", palavra_a); end
        checks++; if (a_pr - p0 !== 0) begin errors++; $display("FAIL timeout_sem_pronto got %0d exp 0", a_pr - p0); end
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL timeout_estado got %0d exp 0", db_a); end
        p0 = a_pr; t0 = a_to;
        send_frame(0, CPB_A, 1, 8'hAB, 0, 1'b1);
        send_frame(0, CPB_A, 1, 8'hCD, 0, 1'b1);
        drive(0, 1'b1, 3 * CPB_A); #1;
        checks++; if (palavra_a !== 16'hCDAB) begin errors++; $display("FAIL pos_timeout_palavra got %h exp cdab", palavra_a); end
        checks++; if (a_pr - p0 !== 1) begin errors++; $display("FAIL pos_timeout_pronto got %0d exp 1", a_pr - p0); end
        checks++; if (a_to - t0 !== 0) begin errors++; $display("FAIL pos_timeout_sem_timeout got %0d exp 0", a_to - t0); end
    endtask

    task automatic test_false_start;
        int p0, e0;
        p0 = a_pr; e0 = a_par + a_quad + a_to;
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 0); #1;
        checks++; if (db_a !== 4'd1) begin errors++; $display("FAIL glitch_start got %0d exp 1", db_a); end
        drive(0, 1'b1, 20); #1;
        checks++; if (db_a !== 4'd0) begin errors++; $display("FAIL glitch_ocioso got %0d exp 0", db_a); end
        checks++; if (a_pr - p0 !== 0) begin errors++; $display("FAIL glitch_pronto got %0d exp 0", a_pr - p0); end
        checks++; if (a_par + a_quad + a_to - e0 !== 0) begin errors++; $display("FAIL glitch_erros got %0d exp 0", a_par + a_quad + a_to - e0); end
        checks++; if (palavra_a !== 16'hCDAB) begin errors++; $display("FAIL glitch_palavra got %h exp cdab", palavra_a); end
    endtask

    task automatic test_habilita;
        int p0, b0;
        hab_a = 1'b0;
        p0 = a_pr; b0 = a_busy;
        send_frame(0, CPB_A, 1, 8'h77, 0, 1'b1);
        drive(0, 1'b1, 2 * CPB_A); #1;
        checks++; if (a_busy - b0 !== 0) begin errors++; $display("FAIL desabilitado_estado got %0d exp 0", a_busy - b0); end
        checks++; if (a_pr - p0 !== 0) begin errors++; $display("FAIL desabilitado_pronto got %0d exp 0", a_pr - p0); end
        hab_a = 1'b1;
        drive(0, 1'b1, 2);
        fork
            send_frame(0, CPB_A, 1, 8'h5A, 0, 1'b1);
            begin
                repeat (3 * CPB_A) @(negedge clk);
                hab_a = 1'b0;
            end
        join
        send_frame(0, CPB_A, 1, 8'hA5, 0, 1'b1);
        drive(0, 1'b1, 3 * CPB_A); #1;
        checks++; if (a_pr - p0 !== 1) begin errors++; $display("FAIL hab_meio_pronto got %0d exp 1", a_pr - p0); end
        checks++; if (palavra_a !== 16'hA55A) begin errors++; $display("FAIL hab_meio_palavra got %h exp a55a", palavra_a); end
        hab_a = 1'b1;
    endtask

    task automatic test_back_to_back_b;
        int p0, e0;
        p0 = b_pr; e0 = b_err;
        send_frame(1, CPB_B, 2, 8'h11, 0, 1'b1);
        send_frame(1, CPB_B, 2, 8'h22, 0, 1'b1);
        send_frame(1, CPB_B, 2, 8'h33, 0, 1'b1);
        drive(1, 1'b1, 3 * CPB_B); #1;
        checks++; if (b_pr - p0 !== 1) begin errors++; $display("FAIL b_pronto got %0d exp 1", b_pr - p0); end
        checks++; if (palavra_b !== 24'h332211) begin errors++; $display("FAIL b_palavra got %h exp 332211", palavra_b); end
        checks++; if (b_err - e0 !== 0) begin errors++; $display("FAIL b_erros got %0d exp 0", b_err - e0); end
    endtask

    task automatic test_reset_mid_frame_b;
        int p0, e0;
        p0 = b_pr; e0 = b_err;
        send_frame(1, CPB_B, 2, 8'h44, 0, 1'b1);
        drive(1, 1'b0, CPB_B);
        drive(1, 1'b1, CPB_B);
        drive(1, 1'b0, CPB_B);
        drive(1, 1'b1, CPB_B);
        rst_b = 1'b0;
        drive(1, 1'b1, 3); #1;
        checks++; if (palavra_b !== 24'h000000) begin errors++; $display("FAIL b_reset_palavra got %h exp 000000", palavra_b); end
        checks++; if (db_b !== 4'd0) begin errors++; $display("FAIL b_reset_estado got %0d exp 0", db_b); end
        rst_b = 1'b1;
        drive(1, 1'b1, 4 * CPB_B); #1;
        checks++; if (b_pr - p0 !== 0) begin errors++; $display("FAIL b_reset_pronto got %0d exp 0", b_pr - p0); end
        checks++; if (b_err - e0 !== 0) begin errors++; $display("FAIL b_reset_erros got %0d exp 0", b_err - e0); end
        send_frame(1, CPB_B, 2, 8'h01, 0, 1'b1);
        send_frame(1, CPB_B, 2, 8'h02, 0, 1'b1);
        send_frame(1, CPB_B, 2, 8'h03, 0, 1'b1);
        drive(1, 1'b1, 3 * CPB_B); #1;
        checks++; if (palavra_b !== 24'h030201) begin errors++; $display("FAIL b_pos_reset_palavra got %h exp 030201", palavra_b); end
        checks++; if (b_pr - p0 !== 1) begin errors++; $display("FAIL b_pos_reset_pronto got %0d exp 1", b_pr - p0); end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        hab_a = 1'b1; hab_b = 1'b1;
        rx_a  = 1'b1; rx_b  = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        test_reset;
        test_two_bytes;
        test_parity_error;
        test_frame_error;
        test_timeout;
        test_false_start;
        test_habilita;
        test_back_to_back_b;
        test_reset_mid_frame_b;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
